pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS pipeline. It drives the enable and flush inputs of the PC and the IF_ID, ID_EX, EX_ME and ME_WB stage registers, and it selects EX-stage operand forwarding sources. It resolves load-use hazards, taken-branch squashes and multi-cycle data-memory waits, with a timeout error and a stall-cycle performance counter.

Parameters:
TIMEOUT, 16, number of consecutive MEM_WAIT cycles before entering ERR (valid range 1..255).
PERF_W, 32, width of the stall_cnt performance counter.

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
id_rs, id_rt  in  5 each  source registers of the instruction in ID
id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs/rt
ex_rs, ex_rt  in  5 each  source registers of the instruction in EX
ex_mem2reg, ex_regwr  in  1 each  EX instruction is a load / writes a register
ex_rd  in  5  EX destination register
me_regwr  in  1  ME instruction writes a register
me_rd  in  5  ME destination register
wb_regwr  in  1  WB instruction writes a register
wb_rd  in  5  WB destination register
branch_taken  in  1  EX resolved a taken branch/jump
mem_req  in  1  ME instruction accesses data memory this cycle
mem_ack  in  1  data memory completes the access this cycle
pc_en, ifid_en, idex_en, exme_en, mewb_en  out  1 each  stage-register load enables
ifid_flush, idex_flush, exme_flush, mewb_flush  out  1 each  synchronous bubble insert (load zeros) into the register
fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 10 ME result, 01 WB result
err  out  1  sticky memory-timeout error
stall_cnt  out  PERF_W  count of cycles with pc_en=0 in RUN/MEM_WAIT

Behaviour:
- State register: RUN, MEM_WAIT, ERR. The wait counter (8 bit), stall_cnt and err are flops. All other outputs are combinational from state and inputs.
- While rst=0: state=RUN, wait counter=0, stall_cnt=0, err=0. All *_en=0, all *_flush=1, fwd_a=fwd_b=00.
- Define memstall = mem_req & ~mem_ack.
- Define loaduse = ex_mem2reg & ex_regwr & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- RUN default: all en=1, all flush=0.
- RUN priority 1, memstall: all en=0, no flush. Next state is MEM_WAIT, wait counter goes to 1.
- RUN priority 2, branch_taken: pc_en=1, ifid_flush=1, idex_flush=1, others advance. Branch beats loaduse, because the ID instruction is squashed.
- RUN priority 3, loaduse: pc_en=0, ifid_en=0, idex_flush=1 (one bubble), exme_en=mewb_en=1.
- MEM_WAIT with mem_ack=1: the cycle behaves exactly as RUN with memstall=0 (branch/loaduse rules apply). Next state is RUN, wait counter goes to 0.
- MEM_WAIT with mem_ack=0: all en=0. The wait counter increments. When the counter equals TIMEOUT, next state is ERR.
- ERR: all en=0, no flush, err=1. ERR is left only by reset.
- A mem_req that drops without an ack while in MEM_WAIT is treated as ack=0 (no abort).
- Forwarding, combinational, in every state:
  - fwd_a=10 if me_regwr & me_rd!=0 & me_rd==ex_rs.
  - Else fwd_a=01 if wb_regwr & wb_rd!=0 & wb_rd==ex_rs.
  - Else fwd_a=00. ME has priority over WB. fwd_b is identical using ex_rt.
- stall_cnt: increments by 1 on each clock edge where the state is not ERR and pc_en=0. It wraps modulo 2^PERF_W.
- Reset is asynchronous mid-operation (e.g. in MEM_WAIT): it returns immediately to the reset values and ignores any pending ack.

Test Plan:
1. Load-use: EX holds lw to $8 (ex_mem2reg=1, ex_regwr=1, ex_rd=8); ID reads id_rs=8 with id_uses_rs=1 → for that cycle pc_en=0, ifid_en=0, idex_flush=1, exme_en=mewb_en=1. stall_cnt goes 0→1. Repeat with ex_rd=0 → no stall.
2. Branch vs load-use: branch_taken=1 together with the load-use condition → pc_en=1, ifid_flush=1, idex_flush=1. stall_cnt is unchanged.
3. Memory wait: mem_req=1, mem_ack=0 for 3 cycles, then mem_ack=1 → all en=0 for 3 cycles (state MEM_WAIT), all en=1 on the ack cycle. stall_cnt=3. Single-cycle ack (req and ack in the same cycle) → no stall.
4. Timeout: with TIMEOUT=4, hold mem_req=1, mem_ack=0 → err=1 after the 5th edge (state ERR), all en=0. A later mem_ack=1 leaves err=1. Pull rst low → err=0, state RUN.
5. Forwarding: me_regwr=1, me_rd=5, wb_regwr=1, wb_rd=5, ex_rs=5, ex_rt=5 → fwd_a=fwd_b=10. Set me_rd=0 → 01. Set wb_regwr=0 → 00.
6. Async reset mid-MEM_WAIT: drop rst between clock edges → outputs take reset values without waiting for an edge. After release with mem_req=0 → state RUN, all en=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- central sequencing controller for the 5-stage MIPS pipeline.
//
// Drives the load enables and bubble-insert (flush) controls of the PC and the
// IF_ID / ID_EX / EX_ME / ME_WB stage registers, and selects the EX-stage
// operand forwarding sources. It resolves:
//   * load-use hazards      -> one-cycle freeze of PC/IF_ID plus an ID_EX bubble
//   * taken branches/jumps  -> squash of the IF_ID and ID_EX contents
//   * data-memory waits     -> whole-pipeline freeze until mem_ack
//   * memory timeouts       -> sticky err and a frozen pipeline until reset
// It also counts the cycles in which the PC was held (stall_cnt).
//
// Parameters
//   TIMEOUT  consecutive MEM_WAIT cycles tolerated before ERR (1..255)
//   PERF_W   width of the stall_cnt performance counter
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   id_rs/id_rt, id_uses_rs/rt    sources of the instruction in ID
//   ex_rs/ex_rt, ex_rd            sources / destination of the EX instruction
//   ex_mem2reg, ex_regwr          EX instruction is a load / writes a register
//   me_regwr/me_rd, wb_regwr/wb_rd  writers in ME and WB (forwarding sources)
//   branch_taken                  EX resolved a taken branch/jump
//   mem_req, mem_ack              data-memory handshake of the ME instruction
//   pc_en..mewb_en                stage-register load enables
//   ifid_flush..mewb_flush        synchronous bubble insert into the register
//   fwd_a, fwd_b                  00 regfile, 10 ME result, 01 WB result
//   err                           sticky memory-timeout error
//   stall_cnt                     cycles with pc_en=0 in RUN/MEM_WAIT
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        ex_rs,
  input  logic [4:0]        ex_rt,
  input  logic              ex_mem2reg,
  input  logic              ex_regwr,
  input  logic [4:0]        ex_rd,
  input  logic              me_regwr,
  input  logic [4:0]        me_rd,
  input  logic              wb_regwr,
  input  logic [4:0]        wb_rd,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exme_en,
  output logic              mewb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exme_flush,
  output logic              mewb_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              err,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  // Forwarding select encoding, as seen by the EX operand muxes.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_ME = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;

  // Enable vector order {pc, ifid, idex, exme, mewb};
  // flush vector order {ifid, idex, exme, mewb}.
  localparam logic [4:0] EN_ALL   = 5'b11111;
  localparam logic [4:0] EN_NONE  = 5'b00000;
  localparam logic [4:0] EN_LU    = 5'b00111;
  localparam logic [3:0] FL_NONE  = 4'b0000;
  localparam logic [3:0] FL_ALL   = 4'b1111;
  localparam logic [3:0] FL_BR    = 4'b1100;
  localparam logic [3:0] FL_LU    = 4'b0100;

  localparam logic [7:0] TIMEOUT_W = TIMEOUT[7:0];
  localparam logic [PERF_W-1:0] STALL_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [7:0]          wait_q, wait_d;
  logic                err_q, err_d;
  logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic                memstall;
  logic                loaduse;
  logic [4:0]          run_en;
  logic [3:0]          run_flush;
  logic [4:0]          en_c;
  logic [3:0]          flush_c;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign memstall = mem_req & ~mem_ack;

  // $0 is hard-wired, so a load "to" $0 never creates a dependency.
  assign loaduse = ex_mem2reg & ex_regwr & (ex_rd != 5'd0) &
                   ((id_uses_rs & (id_rs == ex_rd)) |
                    (id_uses_rt & (id_rt == ex_rd)));

  // Controls for a cycle in which memory is not holding the pipeline.
  // A taken branch wins over load-use: the dependent ID instruction is being
  // squashed anyway, so freezing it would only waste a cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    run_en    = EN_ALL;
    run_flush = FL_NONE;
    if (branch_taken) begin
      run_flush = FL_BR;
    end else if (loaduse) begin
      run_en    = EN_LU;
      run_flush = FL_LU;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and stage controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    en_c    = EN_NONE;
    flush_c = FL_NONE;

    unique case (state_q)
      ST_RUN: begin
        if (memstall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = 8'd1;
        end else begin
          en_c    = run_en;
          flush_c = run_flush;
        end
      end

      ST_MEM_WAIT: begin
        // Only mem_ack releases the wait; a withdrawn mem_req is not an abort.
        if (mem_ack) begin
          en_c    = run_en;
          flush_c = run_flush;
          state_d = ST_RUN;
          wait_d  = 8'd0;
        end else if (wait_q == TIMEOUT_W) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      ST_ERR: begin
        // Frozen until reset; err stays set.
        err_d = 1'b1;
      end

      default: begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
    endcase

    // Reset is asynchronous, so the combinational outputs must also show the
    // reset pattern immediately rather than after the next edge.
    if (!rst) begin
      en_c    = EN_NONE;
      flush_c = FL_ALL;
    end
  end

  // Count held-PC cycles outside ERR; wraps modulo 2^PERF_W.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != ST_ERR) && !en_c[4]) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding: the younger producer (ME) wins over the older one (WB)
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (rst) begin
      if (me_regwr && (me_rd != 5'd0) && (me_rd == ex_rs)) begin
        fwd_a = FWD_ME;
      end else if (wb_regwr && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
        fwd_a = FWD_WB;
      end

      if (me_regwr && (me_rd != 5'd0) && (me_rd == ex_rt)) begin
        fwd_b = FWD_ME;
      end else if (wb_regwr && (wb_rd != 5'd0) && (wb_rd == ex_rt)) begin
        fwd_b = FWD_WB;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // value of the others, independent of statement order.
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_q      <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign {pc_en, ifid_en, idex_en, exme_en, mewb_en}      = en_c;
  assign {ifid_flush, idex_flush, exme_flush, mewb_flush} = flush_c;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule
